// File: rtl/fetch_stage_if.sv
// Bundles the fetch stage's control inputs, instruction-memory port and IF/ID outputs.
// master is the fetch stage itself; slave is the surrounding pipeline and memory.
interface fetch_stage_if #(
  parameter int unsigned PC_WIDTH = 64
);
  logic                enable;
  logic                stall;
  logic                flush;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_rdata;
  logic [PC_WIDTH-1:0] id_pc;
  logic [31:0]         id_instr;
  logic [6:0]          id_opcode;
  logic                id_valid;
  logic                misalign_err;
  logic [31:0]         fetch_count;

  modport master (
    input  enable, stall, flush, redirect, redirect_pc, imem_rdata,
    output imem_addr, id_pc, id_instr, id_opcode, id_valid, misalign_err, fetch_count
  );

  modport slave (
    output enable, stall, flush, redirect, redirect_pc, imem_rdata,
    input  imem_addr, id_pc, id_instr, id_opcode, id_valid, misalign_err, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// captures the fetched instruction plus its PC into the IF/ID register.
module fetch_stage #(
  parameter int unsigned         PC_WIDTH  = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = 32'h0000_0013
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [31:0]         id_instr_q, id_instr_d;
  logic                id_valid_q, id_valid_d;
  logic                misalign_q, misalign_d;
  logic [31:0]         count_q, count_d;
  logic [PC_WIDTH-1:0] pc_inc;

  assign pc_inc = pc_q + PC_WIDTH'(4);

  // Priority: enable=0 > redirect > flush/stall > normal advance.
  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    misalign_d = misalign_q;
    count_d    = count_q;
    if (bus.enable) begin
      if (bus.redirect) begin
        pc_d       = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
        id_pc_d    = '0;
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
        if (bus.redirect_pc[1:0] != 2'b00) begin
          misalign_d = 1'b1;
        end
      end else if (bus.flush) begin
        id_pc_d    = '0;
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
        if (!bus.stall) begin
          pc_d = pc_inc;
        end
      end else if (!bus.stall) begin
        pc_d       = pc_inc;
        id_pc_d    = pc_q;
        id_instr_d = bus.imem_rdata;
        id_valid_d = 1'b1;
        count_d    = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.id_pc        = id_pc_q;
  assign bus.id_instr     = id_instr_q;
  assign bus.id_opcode    = id_instr_q[6:0];
  assign bus.id_valid     = id_valid_q;
  assign bus.misalign_err = misalign_q;
  assign bus.fetch_count  = count_q;

endmodule
